// File: rtl/instr_seq_ctrl_if.sv
// instr_seq_ctrl_if: single-port memory request/ack handshake between the sequencer and memory
interface instr_seq_ctrl_if;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic       mem_ack;
    modport master (output mem_req, output mem_we, output mem_addr, input mem_ack);
    modport slave (input mem_req, input mem_we, input mem_addr, output mem_ack);
endinterface

// File: rtl/instr_seq_ctrl.sv
// instr_seq_ctrl: fetch/decode/execute sequencer owning the pc; SEQ_SINGLE_STEP_EN adds a step input
// that gates each instruction so one executes per step pulse.
module instr_seq_ctrl #(
    parameter int         MEM_TIMEOUT = 16,
    parameter logic [7:0] PC_RESET    = 8'h00
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                    step,
`endif
    input  logic [1:0]              opcode,
    input  logic [7:0]              operand,
    instr_seq_ctrl_if.master        mem,
    output logic                    ir_select,
    output logic                    acc_load,
    output logic                    alu_add,
    output logic [7:0]              pc,
    output logic                    busy,
    output logic                    fault,
    output logic [2:0]              state
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        MEM    = 3'd3,
        FAULT  = 3'd7
    } state_t;
    state_t     cur, nxt;
    logic [7:0] cnt, cnt_nxt, pc_nxt;
    logic       start, cont, req, ack, expired, is_jmp;
`ifdef SEQ_SINGLE_STEP_EN
    assign start = run & step;
    assign cont  = 1'b0;
`else
    assign start = run;
    assign cont  = run;
`endif
    assign req     = cur == FETCH || cur == MEM;
    // reset abandons the request, so an ack in that cycle must not strobe anything
    assign ack     = req & mem.mem_ack & ~reset;
    assign expired = cnt == 8'(MEM_TIMEOUT - 1);
    assign is_jmp  = opcode == 2'b11;
    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= IDLE;
            pc  <= PC_RESET;
            cnt <= '0;
        end else begin
            cur <= nxt;
            pc  <= pc_nxt;
            cnt <= cnt_nxt;
        end
    end
    // counter defaults to clear, so it restarts on every entry to FETCH/MEM and on ack
    always_comb begin
        nxt     = cur;
        pc_nxt  = pc;
        cnt_nxt = '0;
        case (cur)
            IDLE:   nxt = start ? FETCH : IDLE;
            FETCH: begin
                nxt     = ack ? DECODE : expired ? FAULT : FETCH;
                pc_nxt  = ack ? pc + 8'd1 : pc;
                cnt_nxt = ack ? '0 : cnt + 8'd1;
            end
            DECODE: begin
                nxt    = is_jmp ? (cont ? FETCH : IDLE) : MEM;
                pc_nxt = is_jmp ? operand : pc;
            end
            MEM: begin
                nxt     = ack ? (cont ? FETCH : IDLE) : expired ? FAULT : MEM;
                cnt_nxt = ack ? '0 : cnt + 8'd1;
            end
            default: nxt = FAULT;
        endcase
    end
    assign mem.mem_req  = req;
    assign mem.mem_we   = cur == MEM && opcode == 2'b10;
    assign mem.mem_addr = cur == MEM ? operand : cur == FETCH ? pc : '0;
    assign ir_select    = ack && cur == FETCH;
    assign acc_load     = ack && cur == MEM && opcode != 2'b10;
    assign alu_add      = acc_load && opcode == 2'b01;
    assign busy         = cur != IDLE && cur != FAULT;
    assign fault        = cur == FAULT;
    assign state        = cur;
endmodule

// File: tb/tb_instr_seq_ctrl.sv
// tb_instr_seq_ctrl: random and directed stimulus checked against an instruction-level model
module tb_instr_seq_ctrl;
    localparam int TMO = 16;
`ifdef SEQ_SINGLE_STEP_EN
    localparam logic [2:0] BND = 3'd0;
    logic step = 1'b1;
`else
    localparam logic [2:0] BND = 3'd1;
`endif
    logic       clk = 1'b0, reset = 1'b1, run = 1'b0;
    logic [1:0] opcode = '0;
    logic [7:0] operand = '0;
    logic       ir_select, acc_load, alu_add, busy, fault;
    logic [7:0] pc;
    logic [2:0] state;
    instr_seq_ctrl_if mif();
    instr_seq_ctrl #(.MEM_TIMEOUT(TMO), .PC_RESET(8'h00)) dut (
        .clk(clk), .reset(reset), .run(run),
`ifdef SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .opcode(opcode), .operand(operand), .mem(mif.master),
        .ir_select(ir_select), .acc_load(acc_load), .alu_add(alu_add),
        .pc(pc), .busy(busy), .fault(fault), .state(state)
    );
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] addr;
        logic       we;
        logic       fetch;
        logic [1:0] op;
    } txn_t;

    int errors = 0, checks = 0;
    logic [9:0] prog [256];
    logic [7:0] dm [256];
    logic [7:0] m_dm [256];
    logic [9:0] ir = '0;
    logic [7:0] acc = '0, m_acc = '0, m_pc = '0;
    txn_t q [$];
    int   force_wait = 0, wait_left = 0, n_instr = 0;
    logic armed = 1'b0, no_ack = 1'b0;
    logic [2:0] s_state;
    logic [7:0] s_addr, s_pc;
    logic s_req, s_we, s_ack, s_irs, s_accl, s_alu, s_busy, s_fault;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_dm(input logic [7:0] a, input logic [7:0] v);
        dm[a] = v;
        m_dm[a] = v;
    endtask

    // one clock: drive at negedge, sample, score against the model, update bench-side memory/IR/acc
    task automatic tick();
        txn_t t;
        logic exp_irs, exp_accl, exp_alu, hit;
        @(negedge clk);
        opcode = ir[9:8];
        operand = ir[7:0];
        if (mif.mem_req && !armed) begin
            wait_left = no_ack ? 1000 : force_wait >= 0 ? force_wait : int'($urandom_range(0, 3));
            armed = 1'b1;
        end
        mif.mem_ack = mif.mem_req ? wait_left == 0 : 1'($urandom_range(0, 1));
        #1;
        s_state = state; s_req = mif.mem_req; s_we = mif.mem_we; s_addr = mif.mem_addr;
        s_ack = mif.mem_ack; s_irs = ir_select; s_accl = acc_load; s_alu = alu_add;
        s_pc = pc; s_busy = busy; s_fault = fault;
        check("strobe_excl", {31'd0, s_irs & s_accl}, 0);
        if (s_state == 3'd2) check("decode_no_req", {31'd0, s_req}, 0);
        if (!reset && s_req && q.size() == 0) q.push_back('{m_pc, 1'b0, 1'b1, 2'b00});
        if (!reset && s_req) begin
            check("mem_addr", {24'd0, s_addr}, {24'd0, q[0].addr});
            check("mem_we", {31'd0, s_we}, {31'd0, q[0].we});
        end
        if (!reset && s_state == 3'd1) begin
            check("pc", {24'd0, s_pc}, {24'd0, m_pc});
            check("acc", {24'd0, acc}, {24'd0, m_acc});
        end
        hit = !reset && s_req && s_ack;
        exp_irs = hit && q[0].fetch;
        exp_accl = hit && !q[0].fetch && q[0].op != 2'b10;
        exp_alu = exp_accl && q[0].op == 2'b01;
        check("ir_select", {31'd0, s_irs}, {31'd0, exp_irs});
        check("acc_load", {31'd0, s_accl}, {31'd0, exp_accl});
        check("alu_add", {31'd0, s_alu}, {31'd0, exp_alu});
        if (s_irs) ir = prog[s_addr];
        if (s_accl) acc = s_alu ? acc + dm[s_addr] : dm[s_addr];
        if (hit && s_we) dm[s_addr] = acc;
        if (hit) begin
            t = q.pop_front();
            armed = 1'b0;
            if (t.fetch) begin
                n_instr++;
                m_pc = t.addr + 8'd1;
                if (prog[t.addr][9:8] == 2'b11) m_pc = prog[t.addr][7:0];
                else q.push_back('{prog[t.addr][7:0], prog[t.addr][9:8] == 2'b10, 1'b0, prog[t.addr][9:8]});
            end else begin
                case (t.op)
                    2'b00:   m_acc = m_dm[t.addr];
                    2'b01:   m_acc = m_acc + m_dm[t.addr];
                    default: m_dm[t.addr] = m_acc;
                endcase
            end
        end else if (s_req) wait_left--;
        if (reset) begin
            q.delete();
            armed = 1'b0;
            m_pc = 8'h00;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run = 1'b0;
        tick();
        tick();
        check("rst_state", {29'd0, s_state}, 0);
        check("rst_pc", {24'd0, s_pc}, 0);
        check("rst_fault", {31'd0, s_fault}, 0);
        check("rst_busy", {31'd0, s_busy}, 0);
        check("rst_req", {31'd0, s_req}, 0);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] a0;
        int n;
        for (int i = 0; i < 256; i++) begin
            prog[i] = 10'($urandom);
            set_dm(8'(i), 8'($urandom));
        end
        // LDA 05 from reset, zero-wait
        prog[0] = 10'h005;
        set_dm(8'h05, 8'h5A);
        do_reset();
        run = 1'b1;
        tick(); check("t1_idle", {29'd0, s_state}, 0);
        tick(); check("t1_fetch", {29'd0, s_state}, 1); check("t1_sel", {31'd0, s_irs}, 1);
        tick(); check("t1_decode", {29'd0, s_state}, 2); check("t1_pc", {24'd0, s_pc}, 1);
        tick(); check("t1_mem", {29'd0, s_state}, 3); check("t1_addr", {24'd0, s_addr}, 8'h05);
        check("t1_load", {31'd0, s_accl}, 1);
        tick(); check("t1_acc", {24'd0, acc}, 8'h5A); check("t1_bnd", {29'd0, s_state}, {29'd0, BND});
        // JMP FF then ADD at FF: pc wraps
        prog[0] = 10'h3FF;
        prog[8'hFF] = {2'b01, 8'h10};
        set_dm(8'h10, 8'h03);
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 6 && !(s_state == 3'd1 && s_addr == 8'hFF); i++) tick();
        check("t2_fetch_ff", {24'd0, s_addr}, 8'hFF);
        tick(); check("t2_wrap", {24'd0, s_pc}, 8'h00);
        a0 = acc;
        tick(); check("t2_load", {31'd0, s_accl}, 1); check("t2_add", {31'd0, s_alu}, 1);
        check("t2_acc", {24'd0, acc}, {24'd0, 8'(a0 + 8'h03)});
        // JMP 40
        prog[0] = 10'h340;
        do_reset();
        run = 1'b1;
        tick(); tick();
        tick(); check("t3_decode", {29'd0, s_state}, 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (s_state == 3'd1) break;
        end
        check("t3_fetch", {29'd0, s_state}, 1);
        check("t3_addr", {24'd0, s_addr}, 8'h40);
        check("t3_pc", {24'd0, s_pc}, 8'h40);
        // STA 20 with three wait states on every request
        prog[0] = {2'b10, 8'h20};
        do_reset();
        run = 1'b1;
        force_wait = 3;
        tick();
        for (int i = 0; i < 4; i++) tick();
        tick(); check("t4_decode", {29'd0, s_state}, 2);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (s_state == 3'd3 && s_req && s_we && s_addr == 8'h20 && !s_accl) n++;
        end
        check("t4_hold", n, 4);
        check("t4_stored", {24'd0, dm[8'h20]}, {24'd0, acc});
        tick(); check("t4_bnd", {29'd0, s_state}, {29'd0, BND});
        // timeout without any ack
        force_wait = 0;
        do_reset();
        run = 1'b1;
        no_ack = 1'b1;
        tick();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (s_state == 3'd7) break;
            if (s_req) n++;
        end
        check("t5_cycles", n, TMO);
        check("t5_state", {29'd0, s_state}, 7);
        check("t5_fault", {31'd0, s_fault}, 1);
        check("t5_req", {31'd0, s_req}, 0);
        for (int i = 0; i < 5; i++) tick();
        check("t5_sticky", {31'd0, s_fault}, 1);
        check("t5_busy", {31'd0, s_busy}, 0);
        no_ack = 1'b0;
        // ack on the last allowed request cycle
        force_wait = TMO - 1;
        do_reset();
        run = 1'b1;
        tick();
        for (int i = 0; i < TMO - 1; i++) tick();
        tick(); check("t6_ack", {31'd0, s_ack}, 1); check("t6_sel", {31'd0, s_irs}, 1);
        tick(); check("t6_decode", {29'd0, s_state}, 2); check("t6_nofault", {31'd0, s_fault}, 0);
        // reset during MEM with ack
        force_wait = 0;
        prog[0] = 10'h005;
        do_reset();
        run = 1'b1;
        tick(); tick(); tick();
        reset = 1'b1;
        tick(); check("t7_mem", {29'd0, s_state}, 3); check("t7_noload", {31'd0, s_accl}, 0);
        reset = 1'b0;
        tick(); check("t7_state", {29'd0, s_state}, 0); check("t7_pc", {24'd0, s_pc}, 0);
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
        do_reset();
        run = 1'b1;
        tick(); tick(); check("t8_wait", {29'd0, s_state}, 0);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick(); check("t8_fetch", {29'd0, s_state}, 1);
        tick(); tick(); check("t8_mem", {29'd0, s_state}, 3);
        tick(); check("t8_idle", {29'd0, s_state}, 0);
        tick(); check("t8_stay", {29'd0, s_state}, 0);
        step = 1'b1;
`endif
        // random program, random wait states, run toggling
        for (int i = 0; i < 256; i++) begin
            prog[i] = 10'($urandom);
            set_dm(8'(i), 8'($urandom));
        end
        force_wait = -1;
        do_reset();
        n_instr = 0;
        for (int i = 0; i < 1500; i++) begin
            run = $urandom_range(0, 7) != 0;
            tick();
        end
        check("rand_nofault", {31'd0, fault}, 0);
        check("rand_acc", {24'd0, acc}, {24'd0, m_acc});
        check("rand_progress", {31'd0, n_instr > 100}, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
